// File: rtl/gpr_writeback_pkg.sv
// Shared types and defaults for the GPR write-back front end.
// Optional build macro used across this slice: GPR_WB_BYPASS_EN.
package gpr_writeback_pkg;

    localparam int NR_REG_DEF = 16;
    localparam int CNT_W_DEF  = 2;

    // Encodings follow the load funct3 field.
    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } ld_fmt_e;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_req_t;

endpackage

// File: rtl/gpr_writeback_if.sv
// Bundle of issue, result, source-query and GPR write-port signals.
// GPR_WB_BYPASS_EN adds the bypass outputs rs1_byp/rs2_byp/byp_data.
interface gpr_writeback_if;

    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic        iss_ready;

    // Handshakes (alu_*, lsu_*, iss_*): a transfer happens in a cycle where
    // valid & ready are both high at the clock edge; a source that sees
    // ready low keeps valid high and its payload unchanged until it does.
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;

    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic [2:0]  lsu_fmt;
    logic [1:0]  lsu_off;

    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rs1_busy;
    logic        rs2_busy;
`ifdef GPR_WB_BYPASS_EN
    logic        rs1_byp;
    logic        rs2_byp;
    logic [31:0] byp_data;
`endif

    logic        gpr_wen;
    logic [4:0]  gpr_waddr;
    logic [31:0] gpr_wdata;

    modport master (
        output iss_valid, iss_rd, alu_valid, alu_rd, alu_data,
        output lsu_valid, lsu_rd, lsu_data, lsu_fmt, lsu_off, rs1, rs2,
        input  iss_ready, alu_ready, lsu_ready, rs1_busy, rs2_busy,
`ifdef GPR_WB_BYPASS_EN
        input  rs1_byp, rs2_byp, byp_data,
`endif
        input  gpr_wen, gpr_waddr, gpr_wdata
    );

    modport slave (
        input  iss_valid, iss_rd, alu_valid, alu_rd, alu_data,
        input  lsu_valid, lsu_rd, lsu_data, lsu_fmt, lsu_off, rs1, rs2,
        output iss_ready, alu_ready, lsu_ready, rs1_busy, rs2_busy,
`ifdef GPR_WB_BYPASS_EN
        output rs1_byp, rs2_byp, byp_data,
`endif
        output gpr_wen, gpr_waddr, gpr_wdata
    );

endinterface

// File: rtl/gpr_wb_ldext.sv
// Combinational load alignment and sign/zero extension of the raw memory word.
module gpr_wb_ldext
    import gpr_writeback_pkg::*;
(
    input  logic [31:0] raw,
    input  logic [2:0]  fmt,
    input  logic [1:0]  off,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Halfword selection uses only off[1]; a misaligned off[0] is ignored.
    assign byte_sel = raw[{off, 3'b000} +: 8];
    assign half_sel = raw[{off[1], 4'b0000} +: 16];

    always_comb begin
        data = raw;
        case (ld_fmt_e'(fmt))
            LB:      data = {{24{byte_sel[7]}}, byte_sel};
            LH:      data = {{16{half_sel[15]}}, half_sel};
            LBU:     data = {24'h000000, byte_sel};
            LHU:     data = {16'h0000, half_sel};
            default: data = raw;
        endcase
    end

endmodule

// File: rtl/gpr_writeback.sv
// GPR write-back front end: LSU-priority arbiter, registered write port and
// per-register pending-write scoreboard. Build option: GPR_WB_BYPASS_EN.
module gpr_writeback
    import gpr_writeback_pkg::*;
#(
    parameter int NR_REG = NR_REG_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic            clock,
    input  logic            reset,
    gpr_writeback_if.slave  wb
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt [NR_REG];
    logic [31:0]      ld_data;
    wb_req_t          acc;
    logic             acc_valid;
    logic             acc_tracked;
    logic [NR_REG-1:0] inc_v;
    logic [NR_REG-1:0] dec_v;
    logic             iss_at_max;
    logic             rs1_pend;
    logic             rs2_pend;
    logic             retire_on_zero;
    logic             gpr_wen_q;
    logic [4:0]       gpr_waddr_q;
    logic [31:0]      gpr_wdata_q;

    gpr_wb_ldext u_ldext (
        .raw  (wb.lsu_data),
        .fmt  (wb.lsu_fmt),
        .off  (wb.lsu_off),
        .data (ld_data)
    );

    // LSU always wins; the ALU only gets through on a cycle with no load.
    assign wb.lsu_ready = 1'b1;
    assign wb.alu_ready = ~wb.lsu_valid;
    assign acc_valid    = wb.lsu_valid | wb.alu_valid;
    assign acc          = wb.lsu_valid ? wb_req_t'{rd: wb.lsu_rd, data: ld_data}
                                       : wb_req_t'{rd: wb.alu_rd, data: wb.alu_data};
    assign acc_tracked  = acc_valid && (acc.rd != 5'd0) && (int'(acc.rd) < NR_REG);

    always_comb begin
        inc_v          = '0;
        dec_v          = '0;
        iss_at_max     = 1'b0;
        rs1_pend       = 1'b0;
        rs2_pend       = 1'b0;
        retire_on_zero = 1'b0;
        // Register 0 and indices beyond NR_REG never match, so they stay untracked.
        for (int i = 1; i < NR_REG; i++) begin
            if (wb.iss_rd == 5'(i) && cnt[i] == CNT_MAX) iss_at_max = 1'b1;
            if (wb.rs1 == 5'(i) && cnt[i] != '0) rs1_pend = 1'b1;
            if (wb.rs2 == 5'(i) && cnt[i] != '0) rs2_pend = 1'b1;
            if (acc_valid && acc.rd == 5'(i)) begin
                if (cnt[i] != '0) dec_v[i] = 1'b1;
                else              retire_on_zero = 1'b1;
            end
            if (wb.iss_valid && wb.iss_rd == 5'(i) && cnt[i] != CNT_MAX) inc_v[i] = 1'b1;
        end
    end

    assign wb.iss_ready = ~iss_at_max;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NR_REG; i++) cnt[i] <= '0;
        end else begin
            for (int i = 1; i < NR_REG; i++) begin
                if (inc_v[i] && !dec_v[i])      cnt[i] <= cnt[i] + 1'b1;
                else if (dec_v[i] && !inc_v[i]) cnt[i] <= cnt[i] - 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            gpr_wen_q   <= 1'b0;
            gpr_waddr_q <= 5'd0;
            gpr_wdata_q <= 32'd0;
        end else begin
            gpr_wen_q <= acc_tracked;
            if (acc_valid) begin
                gpr_waddr_q <= acc.rd;
                gpr_wdata_q <= acc.data;
            end
        end
    end

    assign wb.gpr_wen   = gpr_wen_q;
    assign wb.gpr_waddr = gpr_waddr_q;
    assign wb.gpr_wdata = gpr_wdata_q;

`ifdef GPR_WB_BYPASS_EN
    // The value in the gpr_* stage is forwarded, so only the counter stalls.
    assign wb.rs1_busy = rs1_pend;
    assign wb.rs2_busy = rs2_pend;
    assign wb.rs1_byp  = gpr_wen_q && (gpr_waddr_q == wb.rs1) && (wb.rs1 != 5'd0);
    assign wb.rs2_byp  = gpr_wen_q && (gpr_waddr_q == wb.rs2) && (wb.rs2 != 5'd0);
    assign wb.byp_data = gpr_wdata_q;
`else
    // Without forwarding, decode must also wait out the write sitting in gpr_*.
    assign wb.rs1_busy = rs1_pend || (gpr_wen_q && gpr_waddr_q == wb.rs1 && wb.rs1 != 5'd0);
    assign wb.rs2_busy = rs2_pend || (gpr_wen_q && gpr_waddr_q == wb.rs2 && wb.rs2 != 5'd0);
`endif

    a_no_underflow: assert property (@(posedge clock) disable iff (reset) !retire_on_zero);

endmodule
